// File: rtl/fetch_exec_ctrl_pkg.sv
// Shared definitions for the accumulator fetch/execute controller:
// bus widths, opcode and state encodings, and the program-counter step.
package fetch_exec_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int OPC_W  = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_JMP   = 3'b100,
        OP_JZ    = 3'b101,
        OP_JC    = 3'b110,
        OP_HALT  = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_OPERAND = 3'd3,
        ST_EXEC    = 3'd4,
        ST_HALT    = 3'd5
    } state_e;

    // The PC is exactly ADDR_W bits wide, so the increment wraps 31 -> 0 on its own.
    function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
        return pc + 5'd1;
    endfunction

endpackage

// File: rtl/fetch_exec_ctrl_if.sv
// Single-port synchronous RAM bus between the controller (master) and the memory (slave).
interface fetch_exec_ctrl_if;
    import fetch_exec_ctrl_pkg::*;

    logic [DATA_W-1:0] ramOut;
    logic [ADDR_W-1:0] ramAddress;
    logic              ramWriteEn;
    logic [DATA_W-1:0] ramDataIn;

    modport master (
        input  ramOut,
        output ramAddress,
        output ramWriteEn,
        output ramDataIn
    );

    modport slave (
        output ramOut,
        input  ramAddress,
        input  ramWriteEn,
        input  ramDataIn
    );

endinterface

// File: rtl/fetch_exec_ctrl_acc_alu.sv
// Combinational accumulator datapath: LOAD/ADD/SUB result with carry (borrow on SUB)
// and a zero flag for the new accumulator value.
module acc_alu
    import fetch_exec_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  opcode_e           opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    assign sum_s  = {1'b0, acc} + {1'b0, operand};
    assign diff_s = {1'b0, acc} - {1'b0, operand};

    // Select the arithmetic result; bit 8 of the 9-bit difference is the borrow.
    always_comb begin
        result = acc;
        carry  = 1'b0;
        case (opcode)
            OP_LOAD: begin
                result = operand;
                carry  = 1'b0;
            end
            OP_ADD: begin
                result = sum_s[DATA_W-1:0];
                carry  = sum_s[DATA_W];
            end
            OP_SUB: begin
                result = diff_s[DATA_W-1:0];
                carry  = diff_s[DATA_W];
            end
            default: begin
                result = acc;
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == 8'h00);

endmodule

// File: rtl/fetch_exec_ctrl.sv
// Multi-cycle accumulator machine: FETCH/DECODE/OPERAND/EXEC sequencing over a
// synchronous RAM, with RAM address and write strobe held in registers.
module fetch_exec_ctrl
    import fetch_exec_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 5'd0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    fetch_exec_ctrl_if.master   bus,
    output logic [DATA_W-1:0]   acc,
    output logic                carry,
    output logic                zero,
    output logic                halted
);

    state_e            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] acc_r;
    logic              carry_r;
    logic              zero_r;
    logic              halted_r;
    logic [ADDR_W-1:0] ram_address_r;
    logic              ram_write_en_r;

    opcode_e           opcode_s;
    opcode_e           decode_opcode_s;
    logic [ADDR_W-1:0] operand_addr_s;
    logic [ADDR_W-1:0] branch_pc_s;
    state_e            resume_state_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              alu_carry_s;
    logic              alu_zero_s;

    assign opcode_s        = opcode_e'(ir_r[7:5]);
    assign operand_addr_s  = ir_r[4:0];
    assign decode_opcode_s = opcode_e'(bus.ramOut[7:5]);

    acc_alu u_acc_alu (
        .acc     (acc_r),
        .operand (bus.ramOut),
        .opcode  (opcode_s),
        .result  (alu_result_s),
        .carry   (alu_carry_s),
        .zero    (alu_zero_s)
    );

    // PC after the OPERAND cycle: taken branches load the operand address,
    // everything else keeps the already-incremented PC.
    always_comb begin
        branch_pc_s = pc_r;
        case (opcode_s)
            OP_JMP: begin
                branch_pc_s = operand_addr_s;
            end
            OP_JZ: begin
                if (zero_r) begin
                    branch_pc_s = operand_addr_s;
                end else begin
                    branch_pc_s = pc_r;
                end
            end
            OP_JC: begin
                if (carry_r) begin
                    branch_pc_s = operand_addr_s;
                end else begin
                    branch_pc_s = pc_r;
                end
            end
            default: begin
                branch_pc_s = pc_r;
            end
        endcase
    end

    // Where a finished instruction goes: next fetch while run is high, otherwise idle.
    always_comb begin
        resume_state_s = ST_IDLE;
        if (run) begin
            resume_state_s = ST_FETCH;
        end else begin
            resume_state_s = ST_IDLE;
        end
    end

    // Controller FSM. The RAM address and write strobe are registered, so each
    // transition also loads the values the next state presents on the bus.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            pc_r           <= RESET_PC;
            ir_r           <= 8'h00;
            acc_r          <= 8'h00;
            carry_r        <= 1'b0;
            zero_r         <= 1'b0;
            halted_r       <= 1'b0;
            ram_address_r  <= RESET_PC;
            ram_write_en_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ram_address_r  <= pc_r;
                    ram_write_en_r <= 1'b0;
                    if (run) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_r        <= ST_DECODE;
                    ram_address_r  <= pc_r;
                    ram_write_en_r <= 1'b0;
                end
                ST_DECODE: begin
                    ir_r           <= bus.ramOut;
                    pc_r           <= pc_incr(pc_r);
                    state_r        <= ST_OPERAND;
                    // OPERAND drives the operand address; a STORE writes in that cycle only.
                    ram_address_r  <= bus.ramOut[4:0];
                    ram_write_en_r <= (decode_opcode_s == OP_STORE);
                end
                ST_OPERAND: begin
                    ram_write_en_r <= 1'b0;
                    case (opcode_s)
                        OP_STORE, OP_JMP, OP_JZ, OP_JC: begin
                            pc_r          <= branch_pc_s;
                            ram_address_r <= branch_pc_s;
                            state_r       <= resume_state_s;
                        end
                        OP_HALT: begin
                            halted_r      <= 1'b1;
                            ram_address_r <= pc_r;
                            state_r       <= ST_HALT;
                        end
                        default: begin
                            ram_address_r <= pc_r;
                            state_r       <= ST_EXEC;
                        end
                    endcase
                end
                ST_EXEC: begin
                    acc_r          <= alu_result_s;
                    zero_r         <= alu_zero_s;
                    ram_address_r  <= pc_r;
                    ram_write_en_r <= 1'b0;
                    state_r        <= resume_state_s;
                    if (opcode_s != OP_LOAD) begin
                        carry_r <= alu_carry_s;
                    end else begin
                        carry_r <= carry_r;
                    end
                end
                ST_HALT: begin
                    halted_r       <= 1'b1;
                    ram_address_r  <= pc_r;
                    ram_write_en_r <= 1'b0;
                    state_r        <= ST_HALT;
                end
                default: begin
                    ram_address_r  <= pc_r;
                    ram_write_en_r <= 1'b0;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ramAddress = ram_address_r;
    assign bus.ramWriteEn = ram_write_en_r;
    assign bus.ramDataIn  = acc_r;
    assign acc            = acc_r;
    assign carry          = carry_r;
    assign zero           = zero_r;
    assign halted         = halted_r;

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Directed bench for fetch_exec_ctrl: two instances (RESET_PC 0 and 31) each with
// a synchronous RAM model; expected values are hand-computed per step.
module tb_fetch_exec_ctrl;
    import fetch_exec_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic run   = 1'b0;
    logic run2  = 1'b0;

    logic [7:0] acc_a, acc_b;
    logic       carry_a, zero_a, halted_a;
    logic       carry_b, zero_b, halted_b;

    logic       load_a = 1'b0;
    logic       load_b = 1'b0;
    logic [4:0] load_addr = 5'd0;
    logic [7:0] load_data = 8'h00;

    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];

    int errors = 0;
    int checks = 0;

    fetch_exec_ctrl_if bus_a ();
    fetch_exec_ctrl_if bus_b ();

    fetch_exec_ctrl #(.RESET_PC(5'd0)) dut_a (
        .clock (clock), .reset (reset), .run (run), .bus (bus_a.master),
        .acc (acc_a), .carry (carry_a), .zero (zero_a), .halted (halted_a)
    );

    fetch_exec_ctrl #(.RESET_PC(5'd31)) dut_b (
        .clock (clock), .reset (reset), .run (run2), .bus (bus_b.master),
        .acc (acc_b), .carry (carry_b), .zero (zero_b), .halted (halted_b)
    );

    always #5 clock = ~clock;

    // RAM models: bench load port has priority, read data registered one cycle after the address.
    always @(posedge clock) begin
        if (load_a) begin
            mem_a[load_addr] <= load_data;
        end else if (bus_a.ramWriteEn) begin
            mem_a[bus_a.ramAddress] <= bus_a.ramDataIn;
        end
        bus_a.ramOut <= mem_a[bus_a.ramAddress];
        if (load_b) begin
            mem_b[load_addr] <= load_data;
        end else if (bus_b.ramWriteEn) begin
            mem_b[bus_b.ramAddress] <= bus_b.ramDataIn;
        end
        bus_b.ramOut <= mem_b[bus_b.ramAddress];
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic sel_b, input logic [4:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_a    = ~sel_b;
        load_b    = sel_b;
        tick(1);
        load_a    = 1'b0;
        load_b    = 1'b0;
    endtask

    // Hold both DUTs in reset and zero both memories.
    task automatic start_test();
        reset = 1'b1;
        run   = 1'b0;
        run2  = 1'b0;
        tick(1);
        for (int i = 0; i < 32; i++) begin
            load_addr = 5'(i);
            load_data = 8'h00;
            load_a    = 1'b1;
            load_b    = 1'b1;
            tick(1);
        end
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick(2);
        check("rst_acc",    {24'd0, acc_a},           32'h00);
        check("rst_flags",  {29'd0, carry_a, zero_a, halted_a}, 32'h0);
        check("rst_addr",   {27'd0, bus_a.ramAddress}, 32'h00);
        check("rst_we",     {31'd0, bus_a.ramWriteEn}, 32'h0);
        check("rst_addr_b", {27'd0, bus_b.ramAddress}, 32'h1F);

        // ---------------- basic program: 5 + 3 stored to M[29], then HALT ----------------
        start_test();
        poke(1'b0, 5'd0, 8'h1E);
        poke(1'b0, 5'd1, 8'h5F);
        poke(1'b0, 5'd2, 8'h3D);
        poke(1'b0, 5'd3, 8'hE0);
        poke(1'b0, 5'd30, 8'h05);
        poke(1'b0, 5'd31, 8'h03);
        reset = 1'b0;
        run   = 1'b1;
        tick(1);
        check("idle_hold_run0_b", {27'd0, bus_b.ramAddress}, 32'h1F);
        tick(4);                       // LOAD is 4 cycles: FETCH of M[1] now
        check("prog_load_acc",  {24'd0, acc_a}, 32'h05);
        check("prog_fetch1",    {27'd0, bus_a.ramAddress}, 32'h01);
        tick(4);                       // ADD is 4 cycles
        check("prog_add_acc",   {24'd0, acc_a}, 32'h08);
        check("prog_fetch2",    {27'd0, bus_a.ramAddress}, 32'h02);
        tick(2);                       // OPERAND of STORE
        check("store_we",       {31'd0, bus_a.ramWriteEn}, 32'h1);
        check("store_addr",     {27'd0, bus_a.ramAddress}, 32'h1D);
        check("store_data",     {24'd0, bus_a.ramDataIn},  32'h08);
        tick(1);
        check("store_we_drop",  {31'd0, bus_a.ramWriteEn}, 32'h0);
        check("prog_fetch3",    {27'd0, bus_a.ramAddress}, 32'h03);
        // 14 cycles from the first FETCH (4+4+3+3) reach HALT on the 15th edge after release.
        tick(2);
        check("not_halted_yet", {31'd0, halted_a}, 32'h0);
        tick(1);
        check("halted",         {31'd0, halted_a}, 32'h1);
        check("prog_acc",       {24'd0, acc_a},    32'h08);
        check("prog_carry",     {31'd0, carry_a},  32'h0);
        check("prog_mem29",     {24'd0, mem_a[29]}, 32'h08);
        run = 1'b0;
        tick(2);
        run = 1'b1;
        tick(2);
        check("halt_sticky",    {31'd0, halted_a}, 32'h1);
        check("halt_addr_pc",   {27'd0, bus_a.ramAddress}, 32'h04);

        // ---------------- carry / zero ----------------
        start_test();
        poke(1'b0, 5'd0, 8'h14);       // LOAD 20
        poke(1'b0, 5'd1, 8'h55);       // ADD 21
        poke(1'b0, 5'd2, 8'h75);       // SUB 21
        poke(1'b0, 5'd3, 8'h16);       // LOAD 22
        poke(1'b0, 5'd4, 8'hE0);
        poke(1'b0, 5'd20, 8'hFF);
        poke(1'b0, 5'd21, 8'h01);
        reset = 1'b0;
        run   = 1'b1;
        tick(5);
        check("cz_load_acc",   {24'd0, acc_a}, 32'hFF);
        check("cz_load_flags", {30'd0, carry_a, zero_a}, 32'h0);
        tick(4);
        check("cz_add_acc",    {24'd0, acc_a}, 32'h00);
        check("cz_add_flags",  {30'd0, carry_a, zero_a}, 32'h3);
        tick(4);
        check("cz_sub_acc",    {24'd0, acc_a}, 32'hFF);
        check("cz_sub_flags",  {30'd0, carry_a, zero_a}, 32'h2);
        tick(4);
        check("cz_load_keeps_c", {30'd0, carry_a, zero_a}, 32'h3);

        // ---------------- branches ----------------
        start_test();
        poke(1'b0, 5'd0,  8'h16);      // LOAD 22 (0) -> zero=1, carry=0
        poke(1'b0, 5'd1,  8'hB0);      // JZ 0x10, taken
        poke(1'b0, 5'd16, 8'hD8);      // JC 0x18, not taken
        poke(1'b0, 5'd17, 8'h77);      // SUB 23 -> 0xFF, carry=1
        poke(1'b0, 5'd18, 8'hA8);      // JZ 0x08, not taken
        poke(1'b0, 5'd19, 8'hDA);      // JC 0x1A, taken
        poke(1'b0, 5'd23, 8'h01);
        poke(1'b0, 5'd26, 8'hE0);
        reset = 1'b0;
        run   = 1'b1;
        tick(8);
        check("jz_taken",     {27'd0, bus_a.ramAddress}, 32'h10);
        tick(3);
        check("jc_not_taken", {27'd0, bus_a.ramAddress}, 32'h11);
        tick(4);
        check("br_sub_flags", {22'd0, acc_a, carry_a, zero_a}, 32'h3FE);
        check("br_sub_fetch", {27'd0, bus_a.ramAddress}, 32'h12);
        tick(3);
        check("jz_not_taken", {27'd0, bus_a.ramAddress}, 32'h13);
        tick(3);
        check("jc_taken",     {27'd0, bus_a.ramAddress}, 32'h1A);

        // ---------------- PC wrap on the RESET_PC=31 instance ----------------
        start_test();
        poke(1'b1, 5'd31, 8'h05);      // LOAD 5
        poke(1'b1, 5'd5,  8'h42);
        poke(1'b1, 5'd0,  8'hE0);
        reset = 1'b0;
        run2  = 1'b1;
        tick(1);
        check("wrap_fetch31", {27'd0, bus_b.ramAddress}, 32'h1F);
        tick(4);
        check("wrap_fetch0",  {27'd0, bus_b.ramAddress}, 32'h00);
        check("wrap_acc",     {24'd0, acc_b}, 32'h42);

        // ---------------- reset during OPERAND of STORE ----------------
        start_test();
        poke(1'b0, 5'd0,  8'h14);      // LOAD 20
        poke(1'b0, 5'd1,  8'h39);      // STORE 25
        poke(1'b0, 5'd20, 8'h77);
        poke(1'b0, 5'd25, 8'hAA);
        reset = 1'b0;
        run   = 1'b1;
        tick(7);
        check("ms_we_before",  {31'd0, bus_a.ramWriteEn}, 32'h1);
        check("ms_addr",       {27'd0, bus_a.ramAddress}, 32'h19);
        #2;
        reset = 1'b1;
        run   = 1'b0;
        #1;
        check("ms_we_async",   {31'd0, bus_a.ramWriteEn}, 32'h0);
        check("ms_addr_rst",   {27'd0, bus_a.ramAddress}, 32'h00);
        tick(1);
        check("ms_mem_kept",   {24'd0, mem_a[25]}, 32'hAA);
        reset = 1'b0;
        tick(3);
        check("ms_idle_addr",  {27'd0, bus_a.ramAddress}, 32'h00);
        check("ms_idle_acc",   {24'd0, acc_a}, 32'h00);
        run = 1'b1;
        tick(5);
        check("ms_restart",    {32'(bus_a.ramAddress) << 8} | 32'(acc_a), 32'h177);

        // ---------------- run drop during DECODE of ADD ----------------
        start_test();
        poke(1'b0, 5'd0,  8'h14);      // LOAD 20
        poke(1'b0, 5'd1,  8'h55);      // ADD 21
        poke(1'b0, 5'd2,  8'hE0);
        poke(1'b0, 5'd20, 8'h10);
        poke(1'b0, 5'd21, 8'h22);
        reset = 1'b0;
        run   = 1'b1;
        tick(6);
        run = 1'b0;
        tick(3);
        check("rd_add_done",   {24'd0, acc_a}, 32'h32);
        for (int i = 0; i < 4; i++) begin
            check("rd_idle_addr", {27'd0, bus_a.ramAddress}, 32'h02);
            check("rd_idle_we",   {31'd0, bus_a.ramWriteEn}, 32'h0);
            tick(1);
        end
        run = 1'b1;
        tick(1);
        check("rd_resume",     {27'd0, bus_a.ramAddress}, 32'h02);
        tick(3);
        check("rd_halted",     {31'd0, halted_a}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
